instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port PS, input, 2, PC select from control word: 00 hold, 01 PC+4, 10 PC<-reg_A, 11 PC<-instr_addr+offset.
REQ-005 SHALL have port IL, input, 1, instruction load request from control word.
REQ-006 SHALL have port PC_sel, input, 1, offset width select: 1 = 26-bit (B), 0 = 19-bit (CB).
REQ-007 SHALL have port K, input, 64, raw branch offset constant from control unit.
REQ-008 SHALL have port reg_A, input, 64, register-file A bus, the BR target.
REQ-009 SHALL have port imem_ack, input, 1, memory read-data-valid.
REQ-010 SHALL have port imem_rdata, input, 32, memory read data.
REQ-011 SHALL have port imem_req, output, 1, read request.
REQ-012 SHALL have port imem_addr, output, 64, read address.
REQ-013 SHALL have port instruction, output, 32, instruction register (IR) contents, fed to control unit.
REQ-014 SHALL have port PC, output, 64, current PC register.
REQ-015 SHALL have port PC4, output, 64, instr_addr+4 (BL link value).
REQ-016 SHALL have port busy, output, 1, high while a fetch is outstanding.
REQ-017 SHALL have port fault, output, 1, sticky misaligned-fetch flag.

Function
REQ-018 SHALL implement FSM states IDLE and WAIT; busy = (state==WAIT); imem_req = (state==WAIT).
REQ-019 In IDLE with IL=1, PC[1:0]==0, fault=0: SHALL latch imem_addr<=PC and instr_addr<=PC, then enter WAIT.
REQ-020 In IDLE with IL=1 and PC[1:0]!=0: SHALL set fault, issue no request, remain IDLE.
REQ-021 In WAIT, imem_addr SHALL remain stable and imem_req high until a cycle with imem_ack=1.
REQ-022 On the edge where imem_req&&imem_ack: SHALL load IR<=imem_rdata and return to IDLE; busy low next cycle.
REQ-023 Minimum fetch latency SHALL be 2 edges (IL edge, ack edge); no upper bound, no timeout.
REQ-024 imem_ack while state==IDLE SHALL be ignored.
REQ-025 PS and IL SHALL be sampled only in IDLE; ignored while busy=1.
REQ-026 PC update in IDLE: 00 PC unchanged; 01 PC<=PC+4; 10 PC<=reg_A; 11 PC<=instr_addr+(sext(offset)<<2).
REQ-027 offset SHALL be K[25:0] sign-extended from bit 25 when PC_sel=1, K[18:0] from bit 18 when PC_sel=0.
REQ-028 All PC arithmetic SHALL be 64-bit modulo 2^64; wrap at 64'hFFFF_FFFF_FFFF_FFFC+4 -> 0 is silent.
REQ-029 IL=1 with PS!=00 same cycle: fetch SHALL use pre-update PC; PC takes the PS result on that edge.
REQ-030 PS=10 to misaligned reg_A SHALL be accepted; fault raised only at the next IL (REQ-020).
REQ-031 Once set, fault SHALL hold and block all fetches until reset.
REQ-032 instruction, PC, PC4 SHALL be registered outputs, never combinational from imem_rdata.

Reset
REQ-033 On reset edge: PC<=RESET_PC, instr_addr<=RESET_PC, IR<=0, imem_addr<=0, state<=IDLE, fault<=0.
REQ-034 Reset mid-fetch SHALL drop imem_req next cycle; any later ack for the aborted fetch ignored per REQ-024.
REQ-035 Reset SHALL take priority over IL, PS and imem_ack in the same cycle.

Verification
REQ-036 Reset, IL=1 PS=01, ack 3 cycles later with rdata=32'h8B020020 -> imem_addr=0, IR=32'h8B020020, PC=4, busy high exactly 3 cycles.
REQ-037 Same-cycle ack (ack=1 while req first asserts) -> IR loads on that edge, busy high 1 cycle, PC4=instr_addr+4.
REQ-038 instr_addr=0x100, PS=11, PC_sel=1, K=26'h3FFFFFE -> PC=0xF8; PC_sel=0, K=19'h00010 -> PC=0x140.
REQ-039 PS=10 reg_A=0x1002, then IL=1 -> fault=1, imem_req never asserts, subsequent IL ignored until reset.
REQ-040 Reset during WAIT then ack next cycle -> imem_req=0, IR=0, PC=RESET_PC, busy=0.
REQ-041 PS/IL toggled while busy -> PC and imem_addr unchanged until ack.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: request/address out, data-valid/data back.
// Request is held with a stable address until a cycle with ack; no other backpressure.
interface instruction_fetch_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// PC/IR fetch stage: one outstanding read, min 2 edges (IL edge, ack edge), unbounded wait.
// Memory stalls by withholding ack; PS/IL from control are ignored while busy.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 PS,
  input  logic                       IL,
  input  logic                       PC_sel,
  input  logic [63:0]                K,
  input  logic [63:0]                reg_A,
  instruction_fetch_if.master        imem,
  output logic [31:0]                instruction,
  output logic [63:0]                PC,
  output logic [63:0]                PC4,
  output logic                       busy,
  output logic                       fault
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  state_t      next_state;
  logic        fetch_go;
  logic        set_fault;
  logic [63:0] instr_addr;
  logic [63:0] addr_q;
  logic [63:0] offset_x4;
  logic [63:0] pc_next;
  logic        k_unused;

  assign k_unused = ^K[63:26];

  // Offset is word-granular, so it is sign-extended and scaled by 4 in one step.
  assign offset_x4 = PC_sel ? {{36{K[25]}}, K[25:0], 2'b00}
                            : {{43{K[18]}}, K[18:0], 2'b00};

  always_comb begin
    case (PS)
      2'b01:   pc_next = PC + 64'd4;
      2'b10:   pc_next = reg_A;
      2'b11:   pc_next = instr_addr + offset_x4;
      default: pc_next = PC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    fetch_go   = 1'b0;
    set_fault  = 1'b0;
    case (state)
      IDLE: begin
        if (IL && !fault) begin
          if (PC[1:0] == 2'b00) begin
            fetch_go   = 1'b1;
            next_state = WAIT;
          end else begin
            set_fault  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem.imem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      PC          <= RESET_PC;
      instr_addr  <= RESET_PC;
      PC4         <= RESET_PC + 64'd4;
      addr_q      <= 64'd0;
      instruction <= 32'd0;
      fault       <= 1'b0;
    end else begin
      // A fetch launched this edge uses the pre-update PC; PC still takes the PS result.
      if (state == IDLE) begin
        PC <= pc_next;
      end
      if (fetch_go) begin
        addr_q     <= PC;
        instr_addr <= PC;
        PC4        <= PC + 64'd4;
      end
      if (set_fault) begin
        fault <= 1'b1;
      end
      if ((state == WAIT) && imem.imem_ack) begin
        instruction <= imem.imem_rdata;
      end
    end
  end

  assign busy           = (state == WAIT);
  assign imem.imem_req  = (state == WAIT);
  assign imem.imem_addr = addr_q;

endmodule
